// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter. Accepts a WIDTH-bit
// word over a valid/ready handshake and shifts it out MSB-first on q, one bit
// per clk, with back-to-back words and no idle gap.
//
// Optional feature: define SER_FRAME_EN to wrap each word in a start bit (1)
// and a stop bit (0); q_last and in_ready then move to the stop-bit cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   din       parallel word, sampled on an accepted handshake
//   in_valid  upstream has a word on din
//   in_ready  block can accept a word this cycle (combinational from state)
//   q         serial data bit (registered)
//   q_valid   q carries a payload/frame bit (registered)
//   q_last    final bit of the word/frame (registered)
//   busy      a word is in flight (state is not IDLE)
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    START = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_d, q_valid_d, q_last_d;
  logic             accept;

  // cnt_q holds the index of the data bit currently presented on q
  assign accept = in_valid & in_ready;
  assign busy   = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef SER_FRAME_EN
        if (accept) state_d = START;
`else
        if (accept) state_d = SHIFT;
`endif
      end
      SHIFT: begin
        if (cnt_q == '0) begin
`ifdef SER_FRAME_EN
          state_d = STOP;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_FRAME_EN
      START: state_d = SHIFT;
      STOP:  state_d = accept ? START : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; in_ready is forced low while in reset
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    q_d       = 1'b0;
    q_valid_d = 1'b0;
    q_last_d  = 1'b0;
`ifdef SER_FRAME_EN
    in_ready  = ~rst & ((state_q == IDLE) | (state_q == STOP));
`else
    in_ready  = ~rst & ((state_q == IDLE) | ((state_q == SHIFT) && (cnt_q == '0)));
`endif
    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
`ifdef SER_FRAME_EN
          // start bit goes out first; the word waits whole in sr
          q_d       = 1'b1;
          sr_d      = din;
`else
          q_d       = din[WIDTH-1];
          sr_d      = {din[WIDTH-2:0], 1'b0};
`endif
          cnt_d     = CW'(WIDTH - 1);
          q_valid_d = 1'b1;
        end
      end
      START: begin
        q_d       = sr_q[WIDTH-1];
        sr_d      = {sr_q[WIDTH-2:0], 1'b0};
        q_valid_d = 1'b1;
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          q_d       = sr_q[WIDTH-1];
          sr_d      = {sr_q[WIDTH-2:0], 1'b0};
          cnt_d     = cnt_q - CW'(1);
          q_valid_d = 1'b1;
`ifndef SER_FRAME_EN
          q_last_d  = (cnt_q == CW'(1));
`endif
        end else begin
`ifdef SER_FRAME_EN
          // stop bit
          q_d       = 1'b0;
          q_valid_d = 1'b1;
          q_last_d  = 1'b1;
`else
          // final bit edge: reload on accept for a gapless next word
          if (accept) begin
            q_d       = din[WIDTH-1];
            sr_d      = {din[WIDTH-2:0], 1'b0};
            cnt_d     = CW'(WIDTH - 1);
            q_valid_d = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      q_last  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q       <= q_d;
      q_valid <= q_valid_d;
      q_last  <= q_last_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer (WIDTH=8): a queue-based reference model of
// the serial stream, a per-cycle compare process, and directed scenarios with
// hand-computed captured-stream expectations.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, q, q_valid, q_last, busy;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q        (q),
    .q_valid  (q_valid),
    .q_last   (q_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: queue of bits still to be sent for the current word
  bit   mq[$];
  logic m_valid = 1'b0;
  logic m_bit   = 1'b0;
  logic m_last  = 1'b0;
  logic m_ready;

  assign m_ready = !rst && (!m_valid || m_last);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_valid <= 1'b0;
      m_bit   <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (in_valid && m_ready) begin
`ifdef SER_FRAME_EN
        mq.push_back(1'b1);
`endif
        for (int i = 7; i >= 0; i--) mq.push_back(din[i]);
`ifdef SER_FRAME_EN
        mq.push_back(1'b0);
`endif
      end
      if (mq.size() > 0) begin
        m_bit   <= mq.pop_front();
        m_last  <= (mq.size() == 0);
        m_valid <= 1'b1;
      end else begin
        m_bit   <= 1'b0;
        m_last  <= 1'b0;
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream capture for literal checks
  logic [31:0] cap  = '0;
  int          vcnt = 0;
  int          rcnt = 0;

  always @(negedge clk) begin
    check1("q", q, m_bit);
    check1("q_valid", q_valid, m_valid);
    check1("q_last", q_last, m_last);
    check1("in_ready", in_ready, m_ready);
    check1("busy", busy, m_valid);
    if (q_valid === 1'b1) begin
      cap  = {cap[30:0], q};
      vcnt = vcnt + 1;
      if (in_ready === 1'b1) rcnt = rcnt + 1;
    end
  end

  task automatic clr();
    cap  = '0;
    vcnt = 0;
    rcnt = 0;
  endtask

  // Present a word and hold in_valid until the handshake completes
  task automatic send(input logic [7:0] w, input bit keep);
    bit acc;
    acc      = 1'b0;
    din      = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = m_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check1("send_timeout", 1'b0, 1'b1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) check1("idle_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check1("rst_q", q, 1'b0);
      check1("rst_q_valid", q_valid, 1'b0);
      check1("rst_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", in_ready, 1'b1);
    check1("busy_after_rst", busy, 1'b0);
    @(posedge clk);
    #1;

    // Single word
    clr();
    send(8'hA5, 1'b0);
    wait_idle();
`ifdef SER_FRAME_EN
    check32("a5_stream", cap, 32'h34A);
    check32("a5_count", 32'(vcnt), 32'd10);
`else
    check32("a5_stream", cap, 32'hA5);
    check32("a5_count", 32'(vcnt), 32'd8);
`endif
    check32("a5_ready_pulses", 32'(rcnt), 32'd1);
    check1("a5_idle_q", q, 1'b0);

    // Back-to-back words
    clr();
    send(8'hFF, 1'b1);
    send(8'h00, 1'b0);
    wait_idle();
`ifdef SER_FRAME_EN
    check32("b2b_stream", cap, 32'hFFA00);
    check32("b2b_count", 32'(vcnt), 32'd20);
`else
    check32("b2b_stream", cap, 32'hFF00);
    check32("b2b_count", 32'(vcnt), 32'd16);
`endif
    check32("b2b_ready_pulses", 32'(rcnt), 32'd2);

    // Ignored input during shifting
    clr();
    send(8'h3C, 1'b0);
    @(posedge clk);
    #1;
    din      = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = 8'h81;
    wait_idle();
`ifdef SER_FRAME_EN
    check32("ign_stream", cap, 32'h278);
    check32("ign_count", 32'(vcnt), 32'd10);
`else
    check32("ign_stream", cap, 32'h3C);
    check32("ign_count", 32'(vcnt), 32'd8);
`endif

    // Two words back-to-back, non-uniform data
    clr();
    send(8'h81, 1'b1);
    send(8'h5A, 1'b0);
    wait_idle();
`ifdef SER_FRAME_EN
    check32("pair_stream", cap, 32'hC0AB4);
    check32("pair_count", 32'(vcnt), 32'd20);
`else
    check32("pair_stream", cap, 32'h815A);
    check32("pair_count", 32'(vcnt), 32'd16);
`endif

    // Reset mid-word
    send(8'hF0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check1("midrst_q", q, 1'b0);
    check1("midrst_q_valid", q_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr();
    repeat (10) @(posedge clk);
    #1;
    check32("midrst_no_resume", 32'(vcnt), 32'd0);
    check1("midrst_idle", busy, 1'b0);

    // A fresh word after the mid-word reset
    clr();
    send(8'hC3, 1'b0);
    wait_idle();
`ifdef SER_FRAME_EN
    check32("post_rst_stream", cap, 32'h386);
`else
    check32("post_rst_stream", cap, 32'hC3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the sending end of the single-bit serial link that the shift-register pipeline consumes on its `d` input.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first, one bit per `clk`, on `q`.
- Supports back-to-back words with no idle gap.
- Qualifier outputs mark valid and last bits for the downstream receiver.

Parameters:
- WIDTH, 8, word width in bits; legal range 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to transmit; sampled only on an accepted handshake.
- in_valid  input  1  upstream has a word on `din`.
- in_ready  output  1  block can accept a word this cycle.
- q  output  1  serial data bit, registered.
- q_valid  output  1  `q` carries a payload (or, with framing, a frame) bit this cycle, registered.
- q_last  output  1  high with the final bit of each word/frame, registered.
- busy  output  1  a word is in flight (state is not IDLE).

Behaviour:
- Reset (`rst`=1, asynchronous):
  - state = IDLE.
  - shift register = 0; bit counter = 0.
  - `q`=0, `q_valid`=0, `q_last`=0, `busy`=0.
  - `in_ready`=0 while `rst` is high; `in_ready`=1 from the first cycle after release.
- Handshake:
  - A word is accepted on a rising edge where `in_valid`=1 and `in_ready`=1.
  - `in_ready` is combinational from state: 1 in IDLE, and 1 during the cycle that carries the final bit (`q_last`=1). It is 0 otherwise.
  - `in_valid` while `in_ready`=0 is ignored. `din` changes while not accepted have no effect.
- States:
  - IDLE:
    - `q`=0, `q_valid`=0.
    - On accept: load `din`, go to SHIFT, counter = WIDTH-1.
  - SHIFT:
    - Each edge: `q` takes the current MSB of the shift register, shift left by 1 with zero fill, counter decrements.
    - `q_last`=1 when the bit being presented is bit 0 of the word.
    - After the final bit: if a new word is accepted on that same edge, reload and stay in SHIFT. Otherwise go to IDLE.
- Latency:
  - Accept at edge N puts MSB on `q` with `q_valid`=1 in the cycle after edge N.
  - Word occupies exactly WIDTH consecutive `q_valid` cycles.
  - Continuous `in_valid` gives 100% link utilisation.
- Counter:
  - Width is clog2(WIDTH).
  - Never wraps below 0; reload at the WIDTH-1 boundary only.
- Simultaneous events:
  - Reset dominates everything.
  - Accept on the final-bit edge is a normal reload; there is no drop and no duplicated bit.
- Reset mid-word: in-flight word is discarded, outputs return to reset values immediately, and transmission does not resume after release.

Optional Feature:
- Macro: SER_FRAME_EN.
- Defined:
  - Each word is framed as a start bit (1), then WIDTH data bits MSB-first, then a stop bit (0). Frame length is WIDTH+2 cycles.
  - Adds states START and STOP around SHIFT.
  - `q_valid`=1 on all frame bits.
  - `q_last` and `in_ready` move to the stop-bit cycle; back-to-back frames start with the start bit on the next cycle.
- Undefined:
  - No start/stop bits; behaviour exactly as above.
  - START and STOP logic is not compiled.

Test Plan (WIDTH=8):
- Reset release: hold `rst` for 3 cycles -> `q`=0, `q_valid`=0, `in_ready`=0 during reset; `in_ready`=1 in the first cycle after release.
- Single word: accept `din`=8'hA5 -> `q` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `q_valid`=1; `q_last`=1 on the 8th only; then IDLE with `q`=0.
- Back-to-back: `in_valid` held high with 8'hFF then 8'h00 -> 16 contiguous `q_valid` cycles (eight 1s then eight 0s); `in_ready` pulses on cycles 8 and 16.
- Ignored input: accept 8'h3C, then toggle `din` and pulse `in_valid` during shifting -> output is still 0,0,1,1,1,1,0,0; no extra word is sent.
- Reset mid-word: accept 8'hF0 and assert `rst` after 3 bits -> `q`/`q_valid`/`busy` go to 0 immediately; after release the block stays idle until a new accept.
- SER_FRAME_EN defined: accept 8'h81 -> 10 valid cycles carrying 1, 1,0,0,0,0,0,0,1, 0; `q_last` on the stop bit; a following word starts on the next cycle.
